data_mem_ctrl: RTL and testbench

//  Parametrised single-port data memory for the CPU MEM stage, with byte-enable writes.

---
 rtl/data_mem_ctrl_if.sv | 43 ++++
 rtl/data_mem_ctrl.sv | 108 ++++++++++
 tb/tb_data_mem_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus for data_mem_ctrl: valid/ready request channel, one-cycle
// registered response channel, plus the initialisation status flag.
interface data_mem_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  init_busy;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_be,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  init_busy
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_be,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output init_busy
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port data memory for the CPU MEM stage: byte-enable writes, valid/ready requests,
// one registered response per accepted request, self-initialising after every reset.
module data_mem_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned INIT_WORDS = 10,
    parameter int unsigned BYTE_ADDR  = 0
) (
    input logic            i_clk,
    input logic            i_reset,
    data_mem_ctrl_if.slave if_bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_run;
    logic              w_accept;
    logic [ADDR_W-1:0] w_word;
    logic              w_range_err;
    logic              w_align_err;
    logic              w_err;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_widx;
    logic              w_init_last;
    logic [DATA_W-1:0] w_init_data;

    assign w_run            = (r_state == ST_RUN);
    assign if_bus.req_ready = w_run;
    assign if_bus.init_busy = !w_run;
    assign w_accept         = if_bus.req_valid && w_run;

    // Range check is done on the full-width word index so high address bits never alias.
    assign w_word      = (BYTE_ADDR != 0) ? (if_bus.req_addr >> OFF_W) : if_bus.req_addr;
    assign w_range_err = (64'(w_word) >= 64'(DEPTH));
    assign w_align_err = (BYTE_ADDR != 0) && ((if_bus.req_addr & OFF_MASK) != '0);
    assign w_err       = w_range_err || w_align_err;
    assign w_widx      = w_word[IDX_W-1:0];
    assign w_wr_en     = w_accept && if_bus.req_we && !w_err;

    assign w_init_last = (r_idx == IDX_W'(DEPTH - 1));
    assign w_init_data = (32'(r_idx) < INIT_WORDS) ? DATA_W'(r_idx) : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_init_last) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // The init sweep and request writes share the single write port; they never overlap
    // because requests are only accepted in RUN.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (r_state == ST_INIT) begin
                r_mem[r_idx] <= w_init_data;
            end else if (w_wr_en) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (if_bus.req_be[b]) begin
                        r_mem[w_widx][8*b +: 8] <= if_bus.req_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // rdata/err only update on an accept so they hold while rsp_valid is low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || if_bus.req_we) ? '0 : r_mem[w_widx];
            end
        end
    end

    assign if_bus.rsp_valid = r_rsp_valid;
    assign if_bus.rsp_rdata = r_rsp_rdata;
    assign if_bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a word-addressed and a byte-addressed instance,
// expected responses queued at accept time and compared when rsp_valid fires.
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
    data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();

    data_mem_ctrl #(
        .DATA_W(32), .DEPTH(128), .ADDR_W(32), .INIT_WORDS(10), .BYTE_ADDR(0)
    ) u_dut_a (
        .i_clk  (clk),
        .i_reset(rst_a),
        .if_bus (bus_a)
    );

    data_mem_ctrl #(
        .DATA_W(32), .DEPTH(128), .ADDR_W(32), .INIT_WORDS(10), .BYTE_ADDR(1)
    ) u_dut_b (
        .i_clk  (clk),
        .i_reset(rst_b),
        .if_bus (bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_rsp_a = 0;
    int n_rsp_b = 0;
    int n_acc_a = 0;
    int n_acc_b = 0;
    logic [32:0] q_a[$];
    logic [32:0] q_b[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (bus_a.rsp_valid === 1'b1) begin
            n_rsp_a++;
            check($sformatf("a_rsp%0d_expected", n_rsp_a), 64'(q_a.size() > 0), 64'd1);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check($sformatf("a_rsp%0d_rdata", n_rsp_a), 64'(bus_a.rsp_rdata), 64'(e[31:0]));
                check($sformatf("a_rsp%0d_err", n_rsp_a), 64'(bus_a.rsp_err), 64'(e[32]));
            end
        end
        if (bus_b.rsp_valid === 1'b1) begin
            n_rsp_b++;
            check($sformatf("b_rsp%0d_expected", n_rsp_b), 64'(q_b.size() > 0), 64'd1);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check($sformatf("b_rsp%0d_rdata", n_rsp_b), 64'(bus_b.rsp_rdata), 64'(e[31:0]));
                check($sformatf("b_rsp%0d_err", n_rsp_b), 64'(bus_b.rsp_err), 64'(e[32]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one request, wait (bounded) for ready, and queue its expected response.
    task automatic issue(input bit sel, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input bit exp_err);
        int n;
        n = 0;
        if (sel) begin
            bus_b.req_valid = 1'b1; bus_b.req_we = we; bus_b.req_addr = addr;
            bus_b.req_wdata = wdata; bus_b.req_be = be;
        end else begin
            bus_a.req_valid = 1'b1; bus_a.req_we = we; bus_a.req_addr = addr;
            bus_a.req_wdata = wdata; bus_a.req_be = be;
        end
        while (((sel ? bus_b.req_ready : bus_a.req_ready) !== 1'b1) && n < 300) begin
            tick(1);
            n++;
        end
        check("req_ready_in_time", 64'(n < 300), 64'd1);
        @(posedge clk);
        if (sel) begin
            q_b.push_back({exp_err, exp_rdata});
            n_acc_b++;
        end else begin
            q_a.push_back({exp_err, exp_rdata});
            n_acc_a++;
        end
        #1;
    endtask

    task automatic idle();
        bus_a.req_valid = 1'b0;
        bus_b.req_valid = 1'b0;
    endtask

    task automatic count_init(input bit sel, output int cnt);
        cnt = 0;
        while (((sel ? bus_b.init_busy : bus_a.init_busy) === 1'b1) && cnt < 1000) begin
            cnt++;
            tick(1);
        end
    endtask

    initial begin
        int cnt;
        int rsp_before;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0;
        bus_a.req_wdata = '0;   bus_a.req_be = '0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
        bus_b.req_wdata = '0;   bus_b.req_be = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick(3);

        check("reset_ready", 64'(bus_a.req_ready), 64'd0);
        check("reset_busy", 64'(bus_a.init_busy), 64'd1);
        check("reset_rsp_valid", 64'(bus_a.rsp_valid), 64'd0);
        check("reset_rsp_rdata", 64'(bus_a.rsp_rdata), 64'd0);
        check("reset_rsp_err", 64'(bus_a.rsp_err), 64'd0);

        // Both instances come out of reset together.
        rst_a = 1'b0;
        rst_b = 1'b0;
        count_init(1'b0, cnt);
        check("init_cycles", 64'(cnt), 64'd128);
        check("run_ready", 64'(bus_a.req_ready), 64'd1);

        issue(0, 0, 32'd5, '0, 4'h0, 32'h0000_0005, 0);
        issue(0, 0, 32'd50, '0, 4'h0, 32'h0000_0000, 0);
        idle();
        tick(2);

        issue(0, 1, 32'd3, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
        issue(0, 0, 32'd3, '0, 4'h0, 32'hDEAD_BEEF, 0);
        idle();
        tick(1);
        check("idle_rsp_valid", 64'(bus_a.rsp_valid), 64'd0);
        check("idle_rdata_hold", 64'(bus_a.rsp_rdata), 64'hDEAD_BEEF);
        check("idle_err_hold", 64'(bus_a.rsp_err), 64'd0);

        issue(0, 1, 32'd7, 32'h0000_AB00, 4'b0010, 32'h0, 0);
        issue(0, 0, 32'd7, '0, 4'h0, 32'h0000_AB07, 0);
        issue(0, 1, 32'd7, 32'hFFFF_FFFF, 4'b0000, 32'h0, 0);
        issue(0, 0, 32'd7, '0, 4'h0, 32'h0000_AB07, 0);
        issue(0, 1, 32'd3, 32'h1100_0000, 4'b1000, 32'h0, 0);
        issue(0, 0, 32'd3, '0, 4'h0, 32'h11AD_BEEF, 0);

        issue(0, 0, 32'd128, '0, 4'h0, 32'h0, 1);
        issue(0, 1, 32'd200, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
        issue(0, 0, 32'd127, '0, 4'h0, 32'h0, 0);
        issue(0, 0, 32'h8000_0005, '0, 4'h0, 32'h0, 1);
        issue(0, 1, 32'h8000_0009, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
        issue(0, 0, 32'd9, '0, 4'h0, 32'h0000_0009, 0);
        issue(0, 0, 32'd0, '0, 4'h0, 32'h0000_0000, 0);
        idle();
        tick(3);
        check("a_queue_drained", 64'(q_a.size()), 64'd0);

        // Reset mid-init with a request held throughout: no response may appear.
        rsp_before = n_rsp_a;
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 32'd2;
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
        tick(40);
        check("midinit_busy", 64'(bus_a.init_busy), 64'd1);
        rst_a = 1'b1;
        tick(1);
        check("reinit_ready", 64'(bus_a.req_ready), 64'd0);
        rst_a = 1'b0;
        count_init(1'b0, cnt);
        bus_a.req_valid = 1'b0;
        check("reinit_cycles", 64'(cnt), 64'd128);
        check("init_no_rsp", 64'(n_rsp_a), 64'(rsp_before));
        issue(0, 0, 32'd3, '0, 4'h0, 32'h0000_0003, 0);
        issue(0, 0, 32'd7, '0, 4'h0, 32'h0000_0007, 0);
        idle();
        tick(2);

        issue(1, 1, 32'h0000_000C, 32'h1234_5678, 4'hF, 32'h0, 0);
        issue(1, 0, 32'h0000_000C, '0, 4'h0, 32'h1234_5678, 0);
        issue(1, 0, 32'h0000_000D, '0, 4'h0, 32'h0, 1);
        issue(1, 1, 32'h0000_0012, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
        issue(1, 0, 32'h0000_0200, '0, 4'h0, 32'h0, 1);
        issue(1, 0, 32'h0000_0000, '0, 4'h0, 32'h0000_0000, 0);
        issue(1, 0, 32'h0000_0004, '0, 4'h0, 32'h0000_0001, 0);
        issue(1, 0, 32'h0000_0008, '0, 4'h0, 32'h0000_0002, 0);
        issue(1, 0, 32'h0000_000C, '0, 4'h0, 32'h1234_5678, 0);
        issue(1, 0, 32'h0000_0010, '0, 4'h0, 32'h0000_0004, 0);
        idle();
        tick(3);

        check("a_final_drained", 64'(q_a.size()), 64'd0);
        check("b_final_drained", 64'(q_b.size()), 64'd0);
        check("a_one_rsp_per_req", 64'(n_rsp_a), 64'(n_acc_a));
        check("b_one_rsp_per_req", 64'(n_rsp_b), 64'(n_acc_b));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
